// File: rtl/rv32i_pkg.sv
// Shared RV32I encodings for the writeback stage.
// Result-select codes and load funct3 values.
package rv32i_pkg;

    localparam logic [1:0] RES_SEL_ALU  = 2'b00;
    localparam logic [1:0] RES_SEL_LOAD = 2'b01;
    localparam logic [1:0] RES_SEL_PC4  = 2'b10;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/wb_stage_v2_if.sv
// MEM->WB handshake bundle plus register-file and bypass outputs.
// master = MEM/hazard side, slave = writeback stage.
interface wb_stage_v2_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
);
    logic              mem_wb_valid;
    logic [XLEN-1:0]   mem_wb_alu;
    logic [XLEN-1:0]   mem_wb_data;
    logic [XLEN-1:0]   mem_wb_pc4;
    logic [REG_AW-1:0] wb_rd_addr;
    logic              wb_reg_write;
    logic [1:0]        wb_res_sel;
    logic [2:0]        wb_ld_funct3;
    logic [1:0]        wb_addr_lo;
    logic              wb_stall;
    logic              wb_flush;
    logic              wb_ready;
    logic              rf_we;
    logic [REG_AW-1:0] rf_waddr;
    logic [XLEN-1:0]   rf_wdata;
    logic              fwd_valid;
    logic [REG_AW-1:0] fwd_rd;
    logic [XLEN-1:0]   fwd_data;

    modport master (
        output mem_wb_valid, mem_wb_alu, mem_wb_data, mem_wb_pc4,
        output wb_rd_addr, wb_reg_write, wb_res_sel, wb_ld_funct3,
        output wb_addr_lo, wb_stall, wb_flush,
        input  wb_ready, rf_we, rf_waddr, rf_wdata,
        input  fwd_valid, fwd_rd, fwd_data
    );

    modport slave (
        input  mem_wb_valid, mem_wb_alu, mem_wb_data, mem_wb_pc4,
        input  wb_rd_addr, wb_reg_write, wb_res_sel, wb_ld_funct3,
        input  wb_addr_lo, wb_stall, wb_flush,
        output wb_ready, rf_we, rf_waddr, rf_wdata,
        output fwd_valid, fwd_rd, fwd_data
    );

endinterface

// File: rtl/wb_stage_v2_load_align.sv
// Sub-word load alignment: picks byte/half by offset, then sign/zero extends.
// Little-endian; addr_lo[0] ignored for halfwords, ignored entirely for words.
module wb_load_align
    import rv32i_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] word,
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    output logic [XLEN-1:0] aligned
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v  = 8'h00;
        half_v  = 16'h0000;
        aligned = word;
        unique case (addr_lo)
            2'd0: byte_v = word[7:0];
            2'd1: byte_v = word[15:8];
            2'd2: byte_v = word[23:16];
            2'd3: byte_v = word[31:24];
            default: byte_v = word[7:0];
        endcase
        half_v = addr_lo[1] ? word[31:16] : word[15:0];
        unique case (1'b1)
            (funct3 == F3_LB):  aligned = {{(XLEN-8){byte_v[7]}}, byte_v};
            (funct3 == F3_LBU): aligned = {{(XLEN-8){1'b0}}, byte_v};
            (funct3 == F3_LH):  aligned = {{(XLEN-16){half_v[15]}}, half_v};
            (funct3 == F3_LHU): aligned = {{(XLEN-16){1'b0}}, half_v};
            default:            aligned = word;
        endcase
    end

endmodule

// File: rtl/wb_stage_v2.sv
// RV32I writeback stage: result mux, one-cycle stage register, x0 suppression.
// Optional retire counter enabled by macro WB_RETIRE_CNT_EN.
module wb_stage_v2
    import rv32i_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
`ifdef WB_RETIRE_CNT_EN
    output logic [CNT_W-1:0] wb_retire_cnt,
`endif
    wb_stage_v2_if.slave     bus
);

    if (XLEN != 32) begin : g_xlen_chk
        $error("wb_stage_v2: only XLEN=32 is supported");
    end

    logic [XLEN-1:0] ld_res;
    logic [XLEN-1:0] res;
    logic            cap;

    wb_load_align #(.XLEN(XLEN)) u_align (
        .word    (bus.mem_wb_data),
        .funct3  (bus.wb_ld_funct3),
        .addr_lo (bus.wb_addr_lo),
        .aligned (ld_res)
    );

    assign cap = bus.mem_wb_valid & ~bus.wb_stall & ~bus.wb_flush;

    always_comb begin
        res = bus.mem_wb_alu;
        unique case (1'b1)
            (bus.wb_res_sel == RES_SEL_LOAD): res = ld_res;
            (bus.wb_res_sel == RES_SEL_PC4):  res = bus.mem_wb_pc4;
            default:                          res = bus.mem_wb_alu;
        endcase
    end

    // Flush only drops the write enable; address/data keep their last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rf_we    <= 1'b0;
            bus.rf_waddr <= '0;
            bus.rf_wdata <= '0;
        end else if (bus.wb_flush) begin
            bus.rf_we    <= 1'b0;
        end else if (!bus.wb_stall) begin
            bus.rf_we    <= cap & bus.wb_reg_write & (bus.wb_rd_addr != '0);
            bus.rf_waddr <= bus.wb_rd_addr;
            bus.rf_wdata <= res;
        end
    end

`ifdef WB_RETIRE_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            wb_retire_cnt <= '0;
        else if (cap)
            wb_retire_cnt <= wb_retire_cnt + 1'b1;
    end
`endif

    assign bus.wb_ready  = ~bus.wb_stall;
    assign bus.fwd_valid = bus.rf_we;
    assign bus.fwd_rd    = bus.rf_waddr;
    assign bus.fwd_data  = bus.rf_wdata;

endmodule
